// File: rtl/uart_pkg.sv
// uart_pkg: types and defaults shared by the UART TX FIFO, scheduler and transmitter
package uart_pkg;
  localparam int UART_DATA_WIDTH = 8;
  typedef enum logic [2:0] {IDLE, READ, FETCH, START, WAIT, GAP} tx_sched_state_t;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer with a configurable reset value
module sync_2ff #(
  parameter int WIDTH = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta;
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: drains the TX FIFO into the UART transmitter; `define UART_TX_CTS_EN adds cts_n flow control
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int GAP_CYCLES = 0,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_req,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  tx_start,
  output logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_done,
`ifdef UART_TX_CTS_EN
  input  logic                  cts_n,
`endif
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  frames_sent
);
  localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
  tx_sched_state_t state;
  logic [GW-1:0] gap_cnt;
  logic cts_ok;
`ifdef UART_TX_CTS_EN
  logic cts_n_s;
  sync_2ff #(.WIDTH(1), .RESET_VAL(1'b1)) u_cts_sync (.clk(clk), .reset(reset), .d(cts_n), .q(cts_n_s));
  assign cts_ok = ~cts_n_s;
`else
  assign cts_ok = 1'b1;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      fifo_rd_req <= 1'b0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      busy        <= 1'b0;
      frames_sent <= '0;
      gap_cnt     <= '0;
    end else begin
      fifo_rd_req <= 1'b0;
      tx_start    <= 1'b0;
      case (state)
        IDLE: if (enable && !fifo_empty && cts_ok) begin
          state       <= READ;
          fifo_rd_req <= 1'b1;
          busy        <= 1'b1;
        end
        READ: state <= FETCH;
        // block-RAM data is valid now, one cycle after the read request
        FETCH: begin
          tx_data     <= fifo_dout;
          tx_start    <= 1'b1;
          frames_sent <= frames_sent + 1'b1;
          state       <= START;
        end
        START: state <= WAIT;
        WAIT: if (tx_done) begin
          if (GAP_CYCLES > 0) begin
            state   <= GAP;
            gap_cnt <= GW'(GAP_CYCLES - 1);
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        GAP: if (gap_cnt == '0) begin
          state <= IDLE;
          busy  <= 1'b0;
        end else begin
          gap_cnt <= gap_cnt - 1'b1;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: two schedulers (gap 0 and gap 4) driven by a FIFO and transmitter model, checked against an event-schedule model
module tb_uart_tx_scheduler;
  localparam int FRAME = 10;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset = 1'b1, enable = 1'b0, cts_n = 1'b0;
  logic fifo_empty [2], fifo_rd_req [2], tx_start [2], tx_done [2], busy [2];
  logic [7:0] fifo_dout [2], tx_data [2];
  logic [15:0] frames_sent [2];
  uart_tx_scheduler #(.GAP_CYCLES(0)) u0 (
    .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty[0]), .fifo_rd_req(fifo_rd_req[0]),
    .fifo_dout(fifo_dout[0]), .tx_start(tx_start[0]), .tx_data(tx_data[0]), .tx_done(tx_done[0]),
`ifdef UART_TX_CTS_EN
    .cts_n(cts_n),
`endif
    .busy(busy[0]), .frames_sent(frames_sent[0]));
  uart_tx_scheduler #(.GAP_CYCLES(4)) u1 (
    .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty[1]), .fifo_rd_req(fifo_rd_req[1]),
    .fifo_dout(fifo_dout[1]), .tx_start(tx_start[1]), .tx_data(tx_data[1]), .tx_done(tx_done[1]),
`ifdef UART_TX_CTS_EN
    .cts_n(cts_n),
`endif
    .busy(busy[1]), .frames_sent(frames_sent[1]));
  int cyc, n_checks, n_fail;
  logic [7:0] fq [2][$];
  logic [7:0] eq [2][$];
  int st_log [2][$];
  int rd_log [2][$];
  logic [7:0] dt_log [2][$];
  bit in_frame [2], pend_rst [2], prev_rd [2];
  int rd_at [2], st_at [2], idle_from [2], tcnt [2];
  logic [7:0] pbyte [2], edata [2];
  logic [15:0] efr [2];
  bit s1, s2, prev_cts, prev_reset;
  int t0, nr;
  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] cycle %0d: got %0h expected %0h", name, i, cyc, act, exp);
    end
  endtask
  function automatic bit cts_ok();
`ifdef UART_TX_CTS_EN
    return !s2;
`else
    return 1'b1;
`endif
  endfunction
  task automatic push(input logic [7:0] b);
    for (int i = 0; i < 2; i++) begin
      fq[i].push_back(b);
      eq[i].push_back(b);
    end
  endtask
  // inputs for the current cycle are final: predict what the schedulers do with them
  task automatic decide();
    for (int i = 0; i < 2; i++) begin
      fifo_empty[i] = fq[i].size() == 0;
      if (reset) pend_rst[i] = 1'b1;
      else if (!in_frame[i]) begin
        if (enable && !fifo_empty[i] && cts_ok()) begin
          in_frame[i]  = 1'b1;
          rd_at[i]     = cyc + 1;
          st_at[i]     = cyc + 3;
          idle_from[i] = -1;
          pbyte[i]     = eq[i].pop_front();
        end
      end else if (st_at[i] < cyc && idle_from[i] < 0 && tx_done[i])
        idle_from[i] = cyc + 1 + (i == 1 ? 4 : 0);
    end
    prev_cts   = cts_n;
    prev_reset = reset;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (prev_reset) begin
      s1 = 1'b1;
      s2 = 1'b1;
    end else begin
      s2 = s1;
      s1 = prev_cts;
    end
    for (int i = 0; i < 2; i++) begin
      if (pend_rst[i]) begin
        in_frame[i] = 1'b0; rd_at[i] = -1; st_at[i] = -1; idle_from[i] = -1;
        edata[i] = 8'h00; efr[i] = 16'h0; pend_rst[i] = 1'b0;
      end else begin
        if (in_frame[i] && idle_from[i] == cyc) in_frame[i] = 1'b0;
        if (st_at[i] == cyc) begin
          edata[i] = pbyte[i];
          efr[i]++;
        end
      end
      chk("fifo_rd_req", i, fifo_rd_req[i], cyc == rd_at[i]);
      chk("tx_start", i, tx_start[i], cyc == st_at[i]);
      chk("busy", i, busy[i], in_frame[i]);
      chk("tx_data", i, tx_data[i], edata[i]);
      chk("frames_sent", i, frames_sent[i], efr[i]);
      if (fifo_rd_req[i]) rd_log[i].push_back(cyc);
      if (tx_start[i]) begin
        st_log[i].push_back(cyc);
        dt_log[i].push_back(tx_data[i]);
      end
      if (prev_rd[i]) begin
        chk("fifo_underflow", i, fq[i].size() > 0, 1);
        if (fq[i].size() > 0) fifo_dout[i] = fq[i].pop_front();
      end
      prev_rd[i] = fifo_rd_req[i];
      tx_done[i] = 1'b0;
      if (tcnt[i] > 0) begin
        tcnt[i]--;
        if (tcnt[i] == 0) tx_done[i] = 1'b1;
      end
      if (tx_start[i]) tcnt[i] = FRAME + 1;
    end
  endtask
  task automatic cycle(input int n);
    repeat (n) begin
      decide();
      step();
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < 2; i++) begin
      fifo_empty[i] = 1'b1; fifo_dout[i] = 8'h00; tx_done[i] = 1'b0;
      in_frame[i] = 1'b0; pend_rst[i] = 1'b0; prev_rd[i] = 1'b0;
      rd_at[i] = -1; st_at[i] = -1; idle_from[i] = -1; tcnt[i] = 0;
      edata[i] = 8'h00; efr[i] = 16'h0; pbyte[i] = 8'h00;
    end
    s1 = 1'b1; s2 = 1'b1;
    cycle(3);
    reset = 1'b0;
    cycle(2);
    for (int i = 0; i < 2; i++) begin
      chk("reset_busy", i, busy[i], 0);
      chk("reset_frames", i, frames_sent[i], 0);
      chk("reset_data", i, tx_data[i], 0);
    end
    enable = 1'b1;
    push(8'hA5);
    t0 = cyc;
    cycle(30);
    chk("first_rd_latency", 0, rd_log[0][0] - t0, 1);
    chk("first_start_latency", 0, st_log[0][0] - t0, 3);
    chk("first_data", 0, dt_log[0][0], 8'hA5);
    chk("first_count", 0, frames_sent[0], 1);
    chk("first_reads", 0, rd_log[0].size(), 1);
    push(8'h11); push(8'h22); push(8'h33);
    cycle(70);
    chk("spacing_12", 0, st_log[0][2] - st_log[0][1], 15);
    chk("spacing_23", 0, st_log[0][3] - st_log[0][2], 15);
    chk("spacing_gap", 1, st_log[1][3] - st_log[1][2], 19);
    chk("gap_delta", 1, (st_log[1][2] - st_log[1][1]) - (st_log[0][2] - st_log[0][1]), 4);
    chk("order_0", 0, dt_log[0][1], 8'h11);
    chk("order_1", 0, dt_log[0][2], 8'h22);
    chk("order_2", 0, dt_log[0][3], 8'h33);
    chk("burst_count", 0, frames_sent[0], 4);
    chk("burst_count", 1, frames_sent[1], 4);
    chk("burst_fifo_empty", 0, fq[0].size(), 0);
    push(8'h44); push(8'h55); push(8'h66);
    cycle(6);
    enable = 1'b0;
    cycle(40);
    chk("pause_count", 0, frames_sent[0], 5);
    chk("pause_count", 1, frames_sent[1], 5);
    chk("pause_queued", 0, fq[0].size(), 2);
    chk("pause_reads", 0, rd_log[0].size(), 5);
    enable = 1'b1;
    cycle(60);
    chk("resume_count", 0, frames_sent[0], 7);
    chk("resume_count", 1, frames_sent[1], 7);
    chk("resume_last", 0, dt_log[0][6], 8'h66);
    chk("resume_empty", 0, fq[0].size(), 0);
    push(8'h77);
    cycle(8);
    reset = 1'b1;
    cycle(1);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("midreset_busy", i, busy[i], 0);
      chk("midreset_frames", i, frames_sent[i], 0);
      chk("midreset_data", i, tx_data[i], 0);
      chk("midreset_start", i, tx_start[i], 0);
    end
    nr = rd_log[0].size();
    cycle(20);
    chk("stray_done_busy", 0, busy[0], 0);
    chk("stray_done_frames", 0, frames_sent[0], 0);
    chk("stray_done_reads", 0, rd_log[0].size(), nr);
`ifdef UART_TX_CTS_EN
    cts_n = 1'b1;
    cycle(3);
    push(8'h88);
    nr = rd_log[0].size();
    cycle(10);
    chk("cts_hold_reads", 0, rd_log[0].size(), nr);
    t0 = cyc;
    cts_n = 1'b0;
    cycle(6);
    chk("cts_rd_latency", 0, rd_log[0][nr] - t0, 3);
    cts_n = 1'b1;
    cycle(40);
    chk("cts_frame_completes", 0, frames_sent[0], 1);
    chk("cts_frame_data", 0, dt_log[0][dt_log[0].size() - 1], 8'h88);
    push(8'h99);
    cycle(10);
    chk("cts_blocks_next", 0, fq[0].size(), 1);
    cts_n = 1'b0;
    cycle(40);
    chk("cts_drain", 0, frames_sent[0], 2);
    chk("cts_drain", 1, frames_sent[1], 2);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
